// File: rtl/key_pkg.sv
// Shared definitions for the push-button reader: per-key FSM encoding and
// default timing constants for a 50 MHz board clock.
package key_pkg;

    typedef enum logic [1:0] {
        KEY_IDLE    = 2'd0,
        KEY_PRESSED = 2'd1,
        KEY_LONG    = 2'd2
    } key_fsm_e;

    localparam int DEB_20MS   = 1000000;
    localparam int LONG_500MS = 25000000;
    localparam int REP_100MS  = 5000000;

endpackage

// File: rtl/key_debounce_one.sv
// One key: 2-FF synchroniser, registered polarity normalisation, debounce
// counter and the IDLE/PRESSED/LONG event FSM with its hold/repeat counters.
module key_debounce_one
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEB_20MS,
    parameter int LONG_CYCLES     = LONG_500MS,
    parameter int REPEAT_CYCLES   = REP_100MS,
    parameter int KEY_ACTIVE_LOW  = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic key_state,
    output logic key_press,
    output logic key_release,
    output logic key_long,
    output logic key_repeat
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(LONG_CYCLES + 1);
    localparam int RW = $clog2(REPEAT_CYCLES + 1);

    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_TOP = HW'(LONG_CYCLES);
    localparam logic [RW-1:0] REP_TOP  = RW'(REPEAT_CYCLES);
    localparam logic          PIN_IDLE = (KEY_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    logic          sync1, sync2, p;
    logic [DW-1:0] deb_cnt, deb_nxt;
    logic [HW-1:0] hold_cnt, hold_nxt, hold_inc;
    logic [RW-1:0] rep_cnt, rep_nxt, rep_inc;
    key_fsm_e      state, state_nxt;
    logic          accept;
    logic          level_nxt, press_nxt, release_nxt, long_nxt, repeat_nxt;

    // The synchroniser resets to the released pin level so no phantom press
    // appears while the chain refills after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= PIN_IDLE;
            sync2 <= PIN_IDLE;
            p     <= 1'b0;
        end else begin
            sync1 <= pin;
            sync2 <= sync1;
            p     <= (KEY_ACTIVE_LOW != 0) ? ~sync2 : sync2;
        end
    end

    always_comb begin
        accept  = 1'b0;
        deb_nxt = '0;
        if (p != key_state) begin
            if (deb_cnt == DEB_LAST) begin
                accept = 1'b1;
            end else begin
                deb_nxt = deb_cnt + DW'(1);
            end
        end
        level_nxt = key_state ^ accept;
    end

    assign hold_inc = hold_cnt + HW'(1);
    assign rep_inc  = (rep_cnt == REP_TOP) ? RW'(1) : rep_cnt + RW'(1);

    // A release accepted on the same cycle as a long/repeat event wins.
    always_comb begin
        state_nxt   = state;
        hold_nxt    = hold_cnt;
        rep_nxt     = rep_cnt;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        long_nxt    = 1'b0;
        repeat_nxt  = 1'b0;
        case (state)
            KEY_IDLE: begin
                hold_nxt = '0;
                rep_nxt  = '0;
                if (accept) begin
                    state_nxt = KEY_PRESSED;
                    press_nxt = 1'b1;
                end
            end
            KEY_PRESSED: begin
                if (accept) begin
                    state_nxt   = KEY_IDLE;
                    release_nxt = 1'b1;
                    hold_nxt    = '0;
                    rep_nxt     = '0;
                end else if (hold_inc == HOLD_TOP) begin
                    state_nxt = KEY_LONG;
                    long_nxt  = 1'b1;
                    hold_nxt  = hold_inc;
                    rep_nxt   = '0;
                end else begin
                    hold_nxt = hold_inc;
                end
            end
            KEY_LONG: begin
                if (accept) begin
                    state_nxt   = KEY_IDLE;
                    release_nxt = 1'b1;
                    hold_nxt    = '0;
                    rep_nxt     = '0;
                end else begin
                    rep_nxt    = rep_inc;
                    repeat_nxt = (rep_inc == REP_TOP);
                end
            end
            default: begin
                state_nxt = KEY_IDLE;
                hold_nxt  = '0;
                rep_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= KEY_IDLE;
            deb_cnt     <= '0;
            hold_cnt    <= '0;
            rep_cnt     <= '0;
            key_state   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;
            key_repeat  <= 1'b0;
        end else begin
            state       <= state_nxt;
            deb_cnt     <= deb_nxt;
            hold_cnt    <= hold_nxt;
            rep_cnt     <= rep_nxt;
            key_state   <= level_nxt;
            key_press   <= press_nxt;
            key_release <= release_nxt;
            key_long    <= long_nxt;
            key_repeat  <= repeat_nxt;
        end
    end

endmodule

// File: rtl/key_reader.sv
// N independent push-button channels: debounced level plus press, release,
// long-press and auto-repeat pulses, all registered in the clk domain.
module key_reader
    import key_pkg::*;
#(
    parameter int N_KEYS          = 4,
    parameter int DEBOUNCE_CYCLES = DEB_20MS,
    parameter int LONG_CYCLES     = LONG_500MS,
    parameter int REPEAT_CYCLES   = REP_100MS,
    parameter int KEY_ACTIVE_LOW  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_in,
    output logic [N_KEYS-1:0] key_state,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_long,
    output logic [N_KEYS-1:0] key_repeat
);

    for (genvar i = 0; i < N_KEYS; i++) begin : g_key
        key_debounce_one #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .LONG_CYCLES    (LONG_CYCLES),
            .REPEAT_CYCLES  (REPEAT_CYCLES),
            .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW)
        ) u_key (
            .clk        (clk),
            .rst        (rst),
            .pin        (key_in[i]),
            .key_state  (key_state[i]),
            .key_press  (key_press[i]),
            .key_release(key_release[i]),
            .key_long   (key_long[i]),
            .key_repeat (key_repeat[i])
        );
    end

endmodule

// File: tb/tb_key_reader.sv
// Bench for key_reader: directed scenarios plus random pin activity, every
// cycle compared against a timing model derived from the key behaviour rules.
module tb_key_reader;

    localparam int N = 4;
    localparam int D = 4;
    localparam int L = 20;
    localparam int R = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] key_in = '1;
    logic [N-1:0] key_state, key_press, key_release, key_long, key_repeat;

    always #5 clk = ~clk;

    key_reader #(
        .N_KEYS(N), .DEBOUNCE_CYCLES(D), .LONG_CYCLES(L),
        .REPEAT_CYCLES(R), .KEY_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst(rst), .key_in(key_in),
        .key_state(key_state), .key_press(key_press), .key_release(key_release),
        .key_long(key_long), .key_repeat(key_repeat)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Reference model: pins reach the debouncer three samples late, a level
    // flips after D consecutive differing samples, events follow from hold time.
    logic [2:0]   pipe [N];
    logic         lvl [N];
    int           run [N];
    int           t_press [N];
    logic [N-1:0] e_state, e_press, e_rel, e_long, e_rep;

    // Observed event log (count and last cycle seen, per key).
    int n_press [N], n_rel [N], n_long [N], n_rep [N];
    int c_press [N], c_rel [N], c_long [N], c_rep [N];
    int n_all, c_all;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < N; k++) begin
            e_press[k] = 1'b0; e_rel[k] = 1'b0; e_long[k] = 1'b0; e_rep[k] = 1'b0;
            if (rst) begin
                pipe[k] = 3'b000; lvl[k] = 1'b0; run[k] = 0;
            end else begin
                logic q, old;
                int   h;
                q = pipe[k][2];
                pipe[k] = {pipe[k][1:0], ~key_in[k]};
                old = lvl[k];
                if (q != old) begin
                    run[k]++;
                    if (run[k] == D) begin
                        lvl[k] = ~old;
                        run[k] = 0;
                    end
                end else begin
                    run[k] = 0;
                end
                if (lvl[k] && !old) begin
                    e_press[k] = 1'b1;
                    t_press[k] = cyc;
                end
                if (!lvl[k] && old) e_rel[k] = 1'b1;
                if (lvl[k] && old) begin
                    h = cyc - t_press[k];
                    e_long[k] = (h == L);
                    e_rep[k]  = (h > L) && ((h - L) % R == 0);
                end
            end
            e_state[k] = lvl[k];
        end
    endtask

    task automatic clear_logs();
        for (int k = 0; k < N; k++) begin
            n_press[k] = 0; n_rel[k] = 0; n_long[k] = 0; n_rep[k] = 0;
            c_press[k] = -1; c_rel[k] = -1; c_long[k] = -1; c_rep[k] = -1;
        end
        n_all = 0; c_all = -1;
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        check("key_state",   {28'b0, key_state},   {28'b0, e_state});
        check("key_press",   {28'b0, key_press},   {28'b0, e_press});
        check("key_release", {28'b0, key_release}, {28'b0, e_rel});
        check("key_long",    {28'b0, key_long},    {28'b0, e_long});
        check("key_repeat",  {28'b0, key_repeat},  {28'b0, e_rep});
        for (int k = 0; k < N; k++) begin
            if (key_press[k] === 1'b1)   begin n_press[k]++; c_press[k] = cyc; end
            if (key_release[k] === 1'b1) begin n_rel[k]++;   c_rel[k]   = cyc; end
            if (key_long[k] === 1'b1)    begin n_long[k]++;  c_long[k]  = cyc; end
            if (key_repeat[k] === 1'b1)  begin n_rep[k]++;   c_rep[k]   = cyc; end
        end
        if (key_press === 4'hF) begin n_all++; c_all = cyc; end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    int t0, t1, tp, tr, tlast;
    int rem [N];

    initial begin
        for (int k = 0; k < N; k++) begin
            pipe[k] = 3'b000; lvl[k] = 1'b0; run[k] = 0; t_press[k] = 0;
        end
        e_state = '0; e_press = '0; e_rel = '0; e_long = '0; e_rep = '0;
        clear_logs();

        // Reset with a pressed pin: nothing may come out.
        rst = 1'b1; key_in = 4'b1110;
        ticks(3);
        check("reset_state", {28'b0, key_state}, 32'h0);
        key_in = '1; rst = 1'b0;
        ticks(8);

        // Clean press on key 0.
        clear_logs();
        key_in[0] = 1'b0; t0 = cyc + 1;
        ticks(12);
        key_in[0] = 1'b1; t1 = cyc + 1;
        ticks(12);
        check("clean_press_time", c_press[0], t0 + 6);
        check("clean_press_count", n_press[0], 1);
        check("clean_release_time", c_rel[0], t1 + 6);
        check("clean_no_long", n_long[0], 0);

        // Bouncing key 1 settling low.
        clear_logs();
        tlast = 0;
        for (int i = 0; i < 14; i++) begin
            key_in[1] = ((i / 2) % 2) != 0;
            if (i == 12) tlast = cyc + 1;
            tick();
        end
        key_in[1] = 1'b0;
        ticks(10);
        check("bounce_press_count", n_press[1], 1);
        check("bounce_press_time", c_press[1], tlast + 6);
        key_in[1] = 1'b1;
        ticks(12);

        // Short glitch on key 2.
        clear_logs();
        key_in[2] = 1'b0;
        ticks(3);
        key_in[2] = 1'b1;
        ticks(12);
        check("glitch_no_press", n_press[2], 0);
        check("glitch_no_release", n_rel[2], 0);

        // Long hold on key 3; release lands on a would-be repeat cycle.
        clear_logs();
        key_in[3] = 1'b0; t0 = cyc + 1;
        ticks(60);
        key_in[3] = 1'b1;
        ticks(12);
        tp = t0 + 6;
        check("long_press_time", c_press[3], tp);
        check("long_long_time", c_long[3], tp + L);
        check("long_long_count", n_long[3], 1);
        check("long_repeat_count", n_rep[3], 4);
        check("long_last_repeat", c_rep[3], tp + L + 4 * R);
        check("long_release_time", c_rel[3], tp + 60);

        // Reset while key 0 sits in the long-hold phase.
        clear_logs();
        key_in[0] = 1'b0;
        ticks(30);
        check("pre_reset_long", n_long[0], 1);
        rst = 1'b1;
        ticks(3);
        rst = 1'b0; tr = cyc + 1;
        ticks(10);
        check("reset_no_release", n_rel[0], 0);
        check("reset_repress_count", n_press[0], 2);
        check("reset_repress_time", c_press[0], tr + 6);
        key_in[0] = 1'b1;
        ticks(12);

        // All four keys at once.
        clear_logs();
        key_in = '0; t0 = cyc + 1;
        ticks(10);
        check("all_press_count", n_all, 1);
        check("all_press_time", c_all, t0 + 6);
        key_in = '1;
        ticks(12);

        // Random pin activity: mostly long holds, some short bounces, rare resets.
        for (int k = 0; k < N; k++) rem[k] = $urandom_range(1, 20);
        for (int i = 0; i < 1500; i++) begin
            for (int k = 0; k < N; k++) begin
                if (rem[k] == 0) begin
                    key_in[k] = ~key_in[k];
                    rem[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3)
                                                         : $urandom_range(5, 70);
                end else begin
                    rem[k]--;
                end
            end
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0;
        ticks(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
